icache_mem_responder: RTL and testbench

- Memory-side responder for the instruction cache's two miss-query channels (q1/q2).
- Accepts one word request at a time and fetches 4 bytes sequentially from the byte-wide main RAM port.
- Assembles the bytes little-endian and returns the word with a one-cycle ready pulse on the requesting channel.
- Sits between the instruction cache and the RAM arbiter; read-only and non-pipelined.

---
 rtl/icache_mem_responder.sv | 130 +++++++++++++
 tb/tb_icache_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_responder.sv
// Read-only memory responder for the instruction cache's two miss channels.
// Fetches one 32-bit word as four sequential byte reads and returns it with a one-cycle ready pulse.
module icache_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter bit Q1_FIRST   = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear,
  input  logic                  q1_valid,
  input  logic [ADDR_WIDTH-1:0] q1_addr,
  output logic [31:0]           q1_result,
  output logic                  q1_ready,
  input  logic                  q2_valid,
  input  logic [ADDR_WIDTH-1:0] q2_addr,
  output logic [31:0]           q2_result,
  output logic                  q2_ready,
  input  logic [7:0]            mem_din,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            r_state;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_chan;
  logic [23:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [31:0]           r_q1_result;
  logic [31:0]           r_q2_result;
  logic                  r_q1_ready;
  logic                  r_q2_ready;

  logic                  w_pick_q2;
  logic [ADDR_WIDTH-1:0] w_next_a;

  // q2 wins only when it is the sole requester or q1 does not have priority
  assign w_pick_q2 = q2_valid && !(q1_valid && Q1_FIRST);
  assign w_next_a  = r_base + ADDR_WIDTH'(r_cnt + 3'd1);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_base      <= '0;
      r_chan      <= 1'b0;
      r_word      <= 24'd0;
      r_mem_a     <= '0;
      r_q1_result <= 32'd0;
      r_q2_result <= 32'd0;
      r_q1_ready  <= 1'b0;
      r_q2_ready  <= 1'b0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_state    <= S_IDLE;
        r_cnt      <= 3'd0;
        r_word     <= 24'd0;
        r_mem_a    <= '0;
        r_q1_ready <= 1'b0;
        r_q2_ready <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (q1_valid || q2_valid) begin
              r_chan  <= w_pick_q2;
              r_base  <= w_pick_q2 ? q2_addr : q1_addr;
              r_mem_a <= w_pick_q2 ? q2_addr : q1_addr;
              r_cnt   <= 3'd0;
              r_word  <= 24'd0;
              r_state <= S_FETCH;
            end else begin
              r_mem_a <= '0;
            end
          end
          S_FETCH: begin
            // mem_din always answers the address driven one cycle earlier
            if (r_cnt == 3'd4) begin
              r_state <= S_DONE;
              r_mem_a <= '0;
              if (r_chan) begin
                r_q2_result <= {mem_din, r_word};
                r_q2_ready  <= 1'b1;
              end else begin
                r_q1_result <= {mem_din, r_word};
                r_q1_ready  <= 1'b1;
              end
            end else begin
              case (r_cnt)
                3'd1:    r_word[7:0]   <= mem_din;
                3'd2:    r_word[15:8]  <= mem_din;
                3'd3:    r_word[23:16] <= mem_din;
                default: r_word        <= r_word;
              endcase
              r_cnt   <= r_cnt + 3'd1;
              r_mem_a <= (r_cnt == 3'd3) ? '0 : w_next_a;
            end
          end
          S_DONE: begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_q1_ready <= 1'b0;
            r_q2_ready <= 1'b0;
          end
          default: begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_mem_a    <= '0;
            r_q1_ready <= 1'b0;
            r_q2_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_a     = r_mem_a;
  assign q1_result = r_q1_result;
  assign q2_result = r_q2_result;
  assign q1_ready  = r_q1_ready;
  assign q2_ready  = r_q2_ready;
  assign mem_dout  = 8'd0;
  assign mem_wr    = 1'b0;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Bench for icache_mem_responder: directed scenarios plus random traffic against a
// transaction-level model that derives each word straight from the RAM contents.
module tb_icache_mem_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rob_clear = 1'b0;
  logic        q1_valid = 1'b0;
  logic [31:0] q1_addr = 32'd0;
  logic [31:0] q1_result;
  logic        q1_ready;
  logic        q2_valid = 1'b0;
  logic [31:0] q2_addr = 32'd0;
  logic [31:0] q2_result;
  logic        q2_ready;
  logic [7:0]  mem_din = 8'd0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles elapsed since accept (-1 when nothing in flight)
  int          m_phase = -1;
  logic [31:0] m_base = 32'd0;
  bit          m_ch = 1'b0;
  logic [31:0] m_res1 = 32'd0;
  logic [31:0] m_res2 = 32'd0;

  icache_mem_responder #(.ADDR_WIDTH(32), .Q1_FIRST(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .q1_valid(q1_valid), .q1_addr(q1_addr), .q1_result(q1_result), .q1_ready(q1_ready),
    .q2_valid(q2_valid), .q2_addr(q2_addr), .q2_result(q2_result), .q2_ready(q2_ready),
    .mem_din(mem_din), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h00;
      32'h102: return 8'h00;
      32'h103: return 8'h93;
      default: begin
        h = a * 32'h9E3779B1;
        return h[31:24] ^ h[15:8] ^ a[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Byte-wide RAM with one cycle of read latency, stalled by the same rdy_in
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= mem_byte(mem_a);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_in) begin
      m_phase = -1; m_base = 32'd0; m_ch = 1'b0; m_res1 = 32'd0; m_res2 = 32'd0;
    end else if (!rdy_in) begin
      // everything holds
    end else if (rob_clear) begin
      m_phase = -1;
    end else if (m_phase < 0) begin
      if (q1_valid || q2_valid) begin
        m_ch    = !q1_valid;
        m_base  = q1_valid ? q1_addr : q2_addr;
        m_phase = 0;
      end
    end else if (m_phase == 5) begin
      m_phase = -1;
    end else begin
      m_phase++;
      if (m_phase == 5) begin
        if (m_ch) m_res2 = mem_word(m_base);
        else      m_res1 = mem_word(m_base);
      end
    end
  endtask

  task automatic step();
    logic [31:0] exp_a;
    bit e1, e2;
    @(posedge clk_in);
    model_edge();
    #1;
    exp_a = (m_phase >= 0 && m_phase <= 3) ? m_base + 32'(m_phase) : 32'd0;
    e1 = (m_phase == 5) && !m_ch;
    e2 = (m_phase == 5) && m_ch;
    check_eq("mem_a", mem_a, exp_a);
    check_eq("q1_ready", {31'd0, q1_ready}, {31'd0, e1});
    check_eq("q2_ready", {31'd0, q2_ready}, {31'd0, e2});
    check_eq("q1_result", q1_result, m_res1);
    check_eq("q2_result", q2_result, m_res2);
    check_eq("mem_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("mem_dout", {24'd0, mem_dout}, 32'd0);
    if (e1 || e2)
      $display("txn ch=q%0d base=%h word=%h", e2 ? 2 : 1, m_base, e2 ? m_res2 : m_res1);
  endtask

  // Step until the model expects a ready pulse; returns the cycles taken
  task automatic wait_ready(input string tag, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (m_phase != 5 && cycles < 40);
    check_eq({tag, "_timeout"}, {31'd0, m_phase == 5}, 32'd1);
  endtask

  int lat;

  initial begin
    step(); step();
    rst_in = 1'b1;

    // single q1 fetch with known bytes
    q1_valid = 1'b1; q1_addr = 32'h100;
    wait_ready("tp1", lat);
    check_eq("tp1_word", q1_result, 32'h93000013);
    check_eq("tp1_latency", lat, 32'd6);
    q1_valid = 1'b0;
    step();

    // simultaneous requests, q1 has priority
    q1_valid = 1'b1; q1_addr = 32'h200; q2_valid = 1'b1; q2_addr = 32'h204;
    wait_ready("tp2a", lat);
    check_eq("tp2_first_q1", {31'd0, q1_ready}, 32'd1);
    q1_valid = 1'b0;
    wait_ready("tp2b", lat);
    check_eq("tp2_gap", lat, 32'd7);
    check_eq("tp2_q2_word", q2_result, mem_word(32'h204));
    q2_valid = 1'b0;
    step();

    // flush at k=2 of a q2 fetch, then a clean q2 fetch
    q2_valid = 1'b1; q2_addr = 32'h280;
    step(); step(); step();
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0; q2_valid = 1'b0;
    step(); step();
    q2_valid = 1'b1; q2_addr = 32'h300;
    wait_ready("tp3", lat);
    check_eq("tp3_latency", lat, 32'd6);
    q2_valid = 1'b0;
    step();

    // three-cycle stall at k=1
    q1_valid = 1'b1; q1_addr = 32'h140;
    step(); step();
    rdy_in = 1'b0;
    step(); step(); step();
    rdy_in = 1'b1;
    wait_ready("tp4", lat);
    check_eq("tp4_latency", lat + 5, 32'd9);
    check_eq("tp4_word", q1_result, mem_word(32'h140));
    q1_valid = 1'b0;
    step();

    // address wrap
    q1_valid = 1'b1; q1_addr = 32'hFFFF_FFFE;
    wait_ready("tp5", lat);
    check_eq("tp5_word", q1_result, {mem_byte(32'h1), mem_byte(32'h0), mem_byte(32'hFFFF_FFFF), mem_byte(32'hFFFF_FFFE)});
    q1_valid = 1'b0;
    step();

    // reset mid-fetch
    q2_valid = 1'b1; q2_addr = 32'h400;
    step(); step(); step();
    rst_in = 1'b0;
    step();
    check_eq("tp6_q1_result", q1_result, 32'd0);
    rst_in = 1'b1; q2_valid = 1'b0;
    step(); step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      q1_valid  = ($urandom_range(0, 3) == 0);
      q2_valid  = ($urandom_range(0, 3) == 0);
      q1_addr   = $urandom;
      q2_addr   = $urandom;
      rdy_in    = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 39) == 0);
      rst_in    = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
